// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer: captures non-x0 register writebacks with a sequence tag
// and streams them to a host over valid/ready; flushes and flags done after halt.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write_sig,
    input  logic [4:0]       reg_num,
    input  logic [31:0]      reg_data,
    input  logic             halt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_reg_num,
    output logic [31:0]      out_reg_data,
    output logic [SEQ_W-1:0] out_seq,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic             done
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [PTR_W:0]   CNT_ZERO   = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [SEQ_W-1:0] SEQ_ZERO   = {SEQ_W{1'b0}};
    localparam logic [SEQ_W-1:0] SEQ_ONE    = {{(SEQ_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic [PTR_W:0]   count_after_pop_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [SEQ_W-1:0] seq_r;
    logic [SEQ_W-1:0] seq_next_s;

    logic [4:0]       num_mem_r  [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [SEQ_W-1:0] seq_mem_r  [DEPTH];

    logic             out_valid_r;
    logic [4:0]       out_reg_num_r;
    logic [31:0]      out_reg_data_r;
    logic [SEQ_W-1:0] out_seq_r;
    logic             overflow_r;
    logic [7:0]       drop_count_r;
    logic             done_r;

    logic             event_s;
    logic             capture_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [4:0]       head_num_s;
    logic [31:0]      head_data_s;
    logic [SEQ_W-1:0] head_seq_s;
    logic [7:0]       drop_count_next_s;

    assign event_s   = reg_write_sig && (reg_num != 5'd0);
    assign capture_s = (state_r == ST_CAPTURE) && event_s;
    assign full_s    = (count_r == CNT_FULL);
    assign pop_s     = (count_r != CNT_ZERO) && out_ready;
    // A full FIFO still takes a new entry when the head leaves in the same cycle
    assign push_s    = capture_s && (!full_s || pop_s);
    assign drop_s    = capture_s && full_s && !pop_s;

    // FIFO occupancy, pointer, sequence and drop bookkeeping
    always_comb begin
        count_next_s      = count_r;
        wr_ptr_next_s     = wr_ptr_r;
        rd_ptr_next_s     = rd_ptr_r;
        seq_next_s        = seq_r;
        drop_count_next_s = drop_count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (capture_s) begin
            seq_next_s = seq_r + SEQ_ONE;
        end else begin
            seq_next_s = seq_r;
        end
        if (drop_s && (drop_count_r != 8'hFF)) begin
            drop_count_next_s = drop_count_r + 8'd1;
        end else begin
            drop_count_next_s = drop_count_r;
        end
    end

    // Head of the FIFO as it will stand after this edge, so outputs can be registered
    always_comb begin
        head_num_s  = 5'd0;
        head_data_s = 32'd0;
        head_seq_s  = SEQ_ZERO;
        if (pop_s) begin
            count_after_pop_s = count_r - CNT_ONE;
        end else begin
            count_after_pop_s = count_r;
        end
        if (count_after_pop_s == CNT_ZERO) begin
            head_num_s  = reg_num;
            head_data_s = reg_data;
            head_seq_s  = seq_r;
        end else begin
            head_num_s  = num_mem_r[rd_ptr_next_s];
            head_data_s = data_mem_r[rd_ptr_next_s];
            head_seq_s  = seq_mem_r[rd_ptr_next_s];
        end
    end

    // Capture / drain / done sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CAPTURE: begin
                if (halt_in) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (count_r == CNT_ZERO) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_DONE;
            default:  state_next_s = ST_CAPTURE;
        endcase
    end

    // Entry storage; contents are only meaningful between the read and write pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            num_mem_r[wr_ptr_r]  <= reg_num;
            data_mem_r[wr_ptr_r] <= reg_data;
            seq_mem_r[wr_ptr_r]  <= seq_r;
        end
    end

    // Control state and registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_CAPTURE;
            count_r        <= CNT_ZERO;
            wr_ptr_r       <= PTR_ZERO;
            rd_ptr_r       <= PTR_ZERO;
            seq_r          <= SEQ_ZERO;
            out_valid_r    <= 1'b0;
            out_reg_num_r  <= 5'd0;
            out_reg_data_r <= 32'd0;
            out_seq_r      <= SEQ_ZERO;
            overflow_r     <= 1'b0;
            drop_count_r   <= 8'd0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            count_r        <= count_next_s;
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            seq_r          <= seq_next_s;
            out_valid_r    <= (count_next_s != CNT_ZERO);
            out_reg_num_r  <= head_num_s;
            out_reg_data_r <= head_data_s;
            out_seq_r      <= head_seq_s;
            overflow_r     <= overflow_r | drop_s;
            drop_count_r   <= drop_count_next_s;
            done_r         <= (state_next_s == ST_DONE);
        end
    end

    assign out_valid    = out_valid_r;
    assign out_reg_num  = out_reg_num_r;
    assign out_reg_data = out_reg_data_r;
    assign out_seq      = out_seq_r;
    assign overflow     = overflow_r;
    assign drop_count   = drop_count_r;
    assign done         = done_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=16, SEQ_W=16).
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        halt_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_reg_num;
    logic [31:0] out_reg_data;
    logic [15:0] out_seq;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(16), .SEQ_W(16)) dut (
        .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
        .reg_data(reg_data), .halt_in(halt_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_num(out_reg_num), .out_reg_data(out_reg_data), .out_seq(out_seq),
        .overflow(overflow), .drop_count(drop_count), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_event(input logic we, input logic [4:0] num, input logic [31:0] data);
        reg_write_sig = we;
        reg_num       = num;
        reg_data      = data;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        halt_in   = 1'b0;
        out_ready = 1'b0;
        drive_event(1'b0, 5'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({out_valid, overflow, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: valid/ovf/done=%b expected 000", {out_valid, overflow, done});
        end
        tests_run++;
        if ({out_reg_num, out_reg_data, out_seq, drop_count} !== 61'd0) begin
            tests_failed++;
            $display("FAIL reset_fields: num=%0d data=%h seq=%0d drops=%0d expected all 0",
                     out_reg_num, out_reg_data, out_seq, drop_count);
        end
    endtask

    task automatic test_basic();
        logic [4:0]  nums  [3] = '{5'd5, 5'd6, 5'd7};
        logic [31:0] datas [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_event(1'b1, nums[i], datas[i]);
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_reg_num !== nums[i] || out_reg_data !== datas[i]
                || out_seq !== 16'(i)) begin
                tests_failed++;
                $display("FAIL basic_entry%0d: v=%b num=%0d data=%h seq=%0d expected v=1 num=%0d data=%h seq=%0d",
                         i, out_valid, out_reg_num, out_reg_data, out_seq, nums[i], datas[i], i);
            end
        end
        drive_event(1'b0, 5'd0, 32'd0);
        step();
        tests_run++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_end: valid=%b overflow=%b expected 0 0", out_valid, overflow);
        end
    endtask

    task automatic test_x0_filter();
        do_reset();
        out_ready = 1'b1;
        drive_event(1'b1, 5'd1, 32'hA1);
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_reg_num !== 5'd1 || out_seq !== 16'd0) begin
            tests_failed++;
            $display("FAIL x0_first: v=%b num=%0d seq=%0d expected 1 1 0", out_valid, out_reg_num, out_seq);
        end
        drive_event(1'b1, 5'd0, 32'hDEAD);
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_ignored: valid=%b expected 0", out_valid);
        end
        drive_event(1'b1, 5'd2, 32'hA2);
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_reg_num !== 5'd2 || out_reg_data !== 32'hA2 || out_seq !== 16'd1) begin
            tests_failed++;
            $display("FAIL x0_second: v=%b num=%0d data=%h seq=%0d expected 1 2 a2 1",
                     out_valid, out_reg_num, out_reg_data, out_seq);
        end
        drive_event(1'b0, 5'd0, 32'd0);
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_event(1'b1, 5'((i % 31) + 1), 32'h100 + 32'(i));
            step();
        end
        drive_event(1'b0, 5'd0, 32'd0);
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== 8'd4 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_flags: ovf=%b drops=%0d valid=%b expected 1 4 1", overflow, drop_count, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_reg_data !== (32'h100 + 32'(i))
                || out_reg_num !== 5'((i % 31) + 1)) begin
                tests_failed++;
                $display("FAIL ovf_drain%0d: v=%b seq=%0d data=%h expected v=1 seq=%0d data=%h",
                         i, out_valid, out_seq, out_reg_data, i, 32'h100 + 32'(i));
            end
            step();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_empty: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int n_seen = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_event(1'b1, 5'd3, 32'h200 + 32'(i));
            step();
        end
        out_ready = 1'b1;
        drive_event(1'b1, 5'd9, 32'hBEEF);
        step();
        tests_run++;
        if (out_seq !== 16'd1 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pp: head seq=%0d drops=%0d ovf=%b expected 1 0 0", out_seq, drop_count, overflow);
        end
        out_ready = 1'b0;
        drive_event(1'b1, 5'd10, 32'hCAFE);
        step();
        drive_event(1'b0, 5'd0, 32'd0);
        tests_run++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_still: drops=%0d ovf=%b expected 1 1", drop_count, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid === 1'b1; i++) begin
            n_seen++;
            if (n_seen == 16) begin
                tests_run++;
                if (out_seq !== 16'd16 || out_reg_data !== 32'hBEEF || out_reg_num !== 5'd9) begin
                    tests_failed++;
                    $display("FAIL full_last: seq=%0d data=%h num=%0d expected 16 beef 9",
                             out_seq, out_reg_data, out_reg_num);
                end
            end
            step();
        end
        tests_run++;
        if (n_seen != 16) begin
            tests_failed++;
            $display("FAIL full_count: drained %0d expected 16", n_seen);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_event(1'b1, 5'(i + 1), 32'h60 + 32'(i));
            step();
        end
        drive_event(1'b1, 5'd8, 32'h66);
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        drive_event(1'b1, 5'd3, 32'h77);
        step();
        step();
        drive_event(1'b0, 5'd0, 32'd0);
        tests_run++;
        if (done !== 1'b0 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL halt_pending: done=%b drops=%0d expected 0 0", done, drop_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_seq !== 16'(i)) begin
                tests_failed++;
                $display("FAIL halt_drain%0d: v=%b seq=%0d expected 1 %0d", i, out_valid, out_seq, i);
            end
            if (i == 5) begin
                tests_run++;
                if (out_reg_num !== 5'd8 || out_reg_data !== 32'h66) begin
                    tests_failed++;
                    $display("FAIL halt_last: num=%0d data=%h expected 8 66", out_reg_num, out_reg_data);
                end
            end
            step();
        end
        tests_run++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_empty: valid=%b done=%b expected 0 0", out_valid, done);
        end
        step();
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_done: done=%b expected 1", done);
        end
        drive_event(1'b1, 5'd4, 32'h88);
        halt_in = 1'b1;
        step();
        step();
        drive_event(1'b0, 5'd0, 32'd0);
        halt_in = 1'b0;
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_hold: done=%b valid=%b expected 1 0", done, out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_event(1'b1, 5'(i + 10), 32'h90 + 32'(i));
            step();
        end
        drive_event(1'b0, 5'd0, 32'd0);
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_pending: valid=%b done=%b expected 1 0", out_valid, done);
        end
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%b done=%b ovf=%b expected 0 0 0", out_valid, done, overflow);
        end
        drive_event(1'b1, 5'd4, 32'h44);
        step();
        drive_event(1'b0, 5'd0, 32'd0);
        tests_run++;
        if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_reg_num !== 5'd4 || out_reg_data !== 32'h44) begin
            tests_failed++;
            $display("FAIL mid_restart: v=%b seq=%0d num=%0d data=%h expected 1 0 4 44",
                     out_valid, out_seq, out_reg_num, out_reg_data);
        end
        step();
    endtask

    initial begin
        reset         = 1'b1;
        halt_in       = 1'b0;
        out_ready     = 1'b0;
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = 32'd0;
        test_reset();
        test_basic();
        test_x0_filter();
        test_overflow();
        test_full_push_pop();
        test_halt();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
